// File: rtl/axi_resp_tracker_pkg.sv
// Shared types and helpers for the AXI response tracker.
//   resp_e    : AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   resp_max  : the more severe of two response codes (numerically largest)
//   beat_inc  : 8-bit saturating beat counter increment
//   DEF_*     : default widths/depths used as parameter defaults
package axi_resp_tracker_pkg;

  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_TS_WIDTH   = 16;
  localparam int DEF_EVT_DEPTH  = 4;
  localparam int LEN_WIDTH      = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [LEN_WIDTH-1:0] beat_inc(input logic [LEN_WIDTH-1:0] b);
    return (b == {LEN_WIDTH{1'b1}}) ? b : b + 1'b1;
  endfunction

endpackage

// File: rtl/axi_resp_tracker_evt_fifo.sv
// Completion-record FIFO with two write ports and one read port.
//   clk_i / reset_i      : clock, asynchronous active-high reset
//   wr0_en_i/wr0_data_i  : first write port (B channel, stored first)
//   wr1_en_i/wr1_data_i  : second write port (R channel, stored after port 0)
//   rd_en_i              : pop request (ignored when empty)
//   rd_data_o            : head record (show-ahead)
//   empty_o / full_o     : occupancy flags
//   drop_o               : a write was refused this cycle because no slot was free
module axi_resp_tracker_evt_fifo
  import axi_resp_tracker_pkg::*;
#(
  parameter int DEPTH = DEF_EVT_DEPTH,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr0_en_i,
  input  logic [W-1:0] wr0_data_i,
  input  logic         wr1_en_i,
  input  logic [W-1:0] wr1_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         drop_o
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_after0;
  logic [AW-1:0] wr1_ptr;
  logic          acc0, acc1, rd;

  // Space is judged on occupancy before any same-cycle pop, so a full FIFO
  // refuses new records even while the consumer is draining it.
  assign acc0       = wr0_en_i && (cnt_q < DEPTH_C);
  assign cnt_after0 = cnt_q + (AW+1)'(acc0);
  assign acc1       = wr1_en_i && (cnt_after0 < DEPTH_C);
  assign wr1_ptr    = wr_ptr_q + AW'(acc0);
  assign rd         = rd_en_i && (cnt_q != '0);
  assign cnt_d      = cnt_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(rd);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (acc0) mem_q[wr_ptr_q] <= wr0_data_i;
      if (acc1) mem_q[wr1_ptr]  <= wr1_data_i;
      wr_ptr_q <= wr_ptr_q + AW'(acc0) + AW'(acc1);
      rd_ptr_q <= rd_ptr_q + AW'(rd);
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == DEPTH_C);
  assign drop_o    = (wr0_en_i && !acc0) || (wr1_en_i && !acc1);

endmodule

// File: rtl/axi_resp_tracker.sv
// Completion-side tracker for pooled AXI IDs.
// Records each issued transaction per ID, snoops B and R handshakes, and for
// every finished transaction queues a completion record and returns the ID
// with a one-cycle dealloc pulse when the record is consumed.
//   clk_i, reset_i            : clock, asynchronous active-high reset
//   issue_*_i                 : new AR/AW transaction (id, addr, len, direction)
//   b_*_i, r_*_i              : snooped B / R channel handshakes and fields
//   dealloc_req_o/dealloc_id_o: ID return pulse, one cycle after a record pop
//   evt_*                     : completion record stream (valid/ready)
//   err_unknown_id_o          : pulse, response on invalid entry or wrong direction
//   err_dup_issue_o           : pulse, issue to an already valid entry
//   err_overflow_o            : sticky, a completion record was dropped
//   outstanding_cnt_o         : number of valid table entries
module axi_resp_tracker
  import axi_resp_tracker_pkg::*;
#(
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int ID_COUNT   = 1 << ID_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int EVT_DEPTH  = DEF_EVT_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  issue_valid_i,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic [7:0]            issue_len_i,
  input  logic                  issue_is_read_i,
  input  logic                  b_valid_i,
  input  logic                  b_ready_i,
  input  logic [ID_WIDTH-1:0]   b_id_i,
  input  logic [1:0]            b_resp_i,
  input  logic                  r_valid_i,
  input  logic                  r_ready_i,
  input  logic [ID_WIDTH-1:0]   r_id_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  r_last_i,
  output logic                  dealloc_req_o,
  output logic [ID_WIDTH-1:0]   dealloc_id_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [ID_WIDTH-1:0]   evt_id_o,
  output logic [ADDR_WIDTH-1:0] evt_addr_o,
  output logic                  evt_is_read_o,
  output logic [TS_WIDTH-1:0]   evt_latency_o,
  output logic [1:0]            evt_resp_o,
  output logic                  evt_beat_err_o,
  output logic                  err_unknown_id_o,
  output logic                  err_dup_issue_o,
  output logic                  err_overflow_o,
  output logic [ID_WIDTH:0]     outstanding_cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic                  is_read;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [TS_WIDTH-1:0]   ts;
    logic [LEN_WIDTH-1:0]  beat;
    logic [1:0]            resp;
  } trk_entry_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_read;
    logic [TS_WIDTH-1:0]   latency;
    logic [1:0]            resp;
    logic                  beat_err;
  } evt_rec_t;

  localparam int REC_W = $bits(evt_rec_t);

  trk_entry_t           tbl [ID_COUNT];
  logic [TS_WIDTH-1:0]  ts_q;
  logic                 b_hs, r_hs, b_done, r_hit, r_done;
  logic                 issue_completes, issue_fresh, issue_dup;
  evt_rec_t             b_rec, r_rec, head_rec;
  logic [REC_W-1:0]     fifo_rd_data;
  logic                 fifo_empty, fifo_full, fifo_drop, pop;

  logic                 dealloc_req_q;
  logic [ID_WIDTH-1:0]  dealloc_id_q;
  logic                 err_unknown_q, err_dup_q, err_overflow_q;
  logic [ID_WIDTH:0]    cnt_q, cnt_d;

  // Response matching. A response only counts against an entry that is valid
  // and of the matching direction; anything else is reported and ignored.
  assign b_hs   = b_valid_i && b_ready_i;
  assign r_hs   = r_valid_i && r_ready_i;
  assign b_done = b_hs && tbl[b_id_i].valid && !tbl[b_id_i].is_read;
  assign r_hit  = r_hs && tbl[r_id_i].valid && tbl[r_id_i].is_read;
  assign r_done = r_hit && r_last_i;

  // An entry completing in the same cycle it is re-issued is handed over
  // cleanly: the completion consumes the old contents, the issue loads the
  // new ones, and it is neither a duplicate nor a change in valid count.
  assign issue_completes = (b_done && (b_id_i == issue_id_i)) ||
                           (r_done && (r_id_i == issue_id_i));
  assign issue_fresh = issue_valid_i && (!tbl[issue_id_i].valid || issue_completes);
  assign issue_dup   = issue_valid_i && tbl[issue_id_i].valid && !issue_completes;

  always_comb begin
    b_rec          = '0;
    b_rec.id       = b_id_i;
    b_rec.addr     = tbl[b_id_i].addr;
    b_rec.is_read  = 1'b0;
    b_rec.latency  = ts_q - tbl[b_id_i].ts;
    b_rec.resp     = resp_max(tbl[b_id_i].resp, b_resp_i);
    b_rec.beat_err = 1'b0;

    r_rec          = '0;
    r_rec.id       = r_id_i;
    r_rec.addr     = tbl[r_id_i].addr;
    r_rec.is_read  = 1'b1;
    r_rec.latency  = ts_q - tbl[r_id_i].ts;
    r_rec.resp     = resp_max(tbl[r_id_i].resp, r_resp_i);
    // Beats seen including this last one is beat+1; expected is len+1.
    r_rec.beat_err = (tbl[r_id_i].beat != tbl[r_id_i].len);
  end

  // Per-ID table entry. Issue has write priority over either response port.
  for (genvar gi = 0; gi < ID_COUNT; gi++) begin : g_entry
    trk_entry_t ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (issue_valid_i && (issue_id_i == ID_WIDTH'(gi))) begin
        ent_d.valid   = 1'b1;
        ent_d.is_read = issue_is_read_i;
        ent_d.addr    = issue_addr_i;
        ent_d.len     = issue_len_i;
        ent_d.ts      = ts_q;
        ent_d.beat    = '0;
        ent_d.resp    = RESP_OKAY;
      end else if (b_done && (b_id_i == ID_WIDTH'(gi))) begin
        ent_d.valid = 1'b0;
      end else if (r_hit && (r_id_i == ID_WIDTH'(gi))) begin
        if (r_last_i) begin
          ent_d.valid = 1'b0;
        end else begin
          ent_d.beat = beat_inc(ent_q.beat);
          ent_d.resp = resp_max(ent_q.resp, r_resp_i);
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) ent_q <= '0;
      else         ent_q <= ent_d;
    end

    assign tbl[gi] = ent_q;
  end

  axi_resp_tracker_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .W     (REC_W)
  ) u_evt_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr0_en_i   (b_done),
    .wr0_data_i (b_rec),
    .wr1_en_i   (r_done),
    .wr1_data_i (r_rec),
    .rd_en_i    (evt_ready_i),
    .rd_data_o  (fifo_rd_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .drop_o     (fifo_drop)
  );

  assign head_rec = evt_rec_t'(fifo_rd_data);
  assign pop      = !fifo_empty && evt_ready_i;

  assign cnt_d = cnt_q + (ID_WIDTH+1)'(issue_fresh)
                       - (ID_WIDTH+1)'(b_done)
                       - (ID_WIDTH+1)'(r_done);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_q           <= '0;
      dealloc_req_q  <= 1'b0;
      dealloc_id_q   <= '0;
      err_unknown_q  <= 1'b0;
      err_dup_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      ts_q           <= ts_q + 1'b1;
      // IDs go back to the pool only once their record has been consumed.
      dealloc_req_q  <= pop;
      dealloc_id_q   <= pop ? head_rec.id : dealloc_id_q;
      err_unknown_q  <= (b_hs && !b_done) || (r_hs && !r_hit);
      err_dup_q      <= issue_dup;
      // A dropped record leaks its ID; this flag is the only trace of it.
      err_overflow_q <= err_overflow_q || fifo_drop;
      cnt_q          <= cnt_d;
    end
  end

  assign dealloc_req_o     = dealloc_req_q;
  assign dealloc_id_o      = dealloc_id_q;
  assign evt_valid_o       = !fifo_empty;
  assign evt_id_o          = head_rec.id;
  assign evt_addr_o        = head_rec.addr;
  assign evt_is_read_o     = head_rec.is_read;
  assign evt_latency_o     = head_rec.latency;
  assign evt_resp_o        = head_rec.resp;
  assign evt_beat_err_o    = head_rec.beat_err;
  assign err_unknown_id_o  = err_unknown_q;
  assign err_dup_issue_o   = err_dup_q;
  assign err_overflow_o    = err_overflow_q;
  assign outstanding_cnt_o = cnt_q;

  // Full is reported by the queue but the tracker reacts only to drops.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_axi_resp_tracker.sv
module tb_axi_resp_tracker;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_id;
  logic [31:0] issue_addr;
  logic [7:0]  issue_len;
  logic        issue_is_read;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        dealloc_req;
  logic [3:0]  dealloc_id;
  logic        evt_valid, evt_ready;
  logic [3:0]  evt_id;
  logic [31:0] evt_addr;
  logic        evt_is_read;
  logic [15:0] evt_latency;
  logic [1:0]  evt_resp;
  logic        evt_beat_err;
  logic        err_unknown_id, err_dup_issue, err_overflow;
  logic [4:0]  outstanding_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  axi_resp_tracker dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .issue_valid_i     (issue_valid),
    .issue_id_i        (issue_id),
    .issue_addr_i      (issue_addr),
    .issue_len_i       (issue_len),
    .issue_is_read_i   (issue_is_read),
    .b_valid_i         (b_valid),
    .b_ready_i         (b_ready),
    .b_id_i            (b_id),
    .b_resp_i          (b_resp),
    .r_valid_i         (r_valid),
    .r_ready_i         (r_ready),
    .r_id_i            (r_id),
    .r_resp_i          (r_resp),
    .r_last_i          (r_last),
    .dealloc_req_o     (dealloc_req),
    .dealloc_id_o      (dealloc_id),
    .evt_valid_o       (evt_valid),
    .evt_ready_i       (evt_ready),
    .evt_id_o          (evt_id),
    .evt_addr_o        (evt_addr),
    .evt_is_read_o     (evt_is_read),
    .evt_latency_o     (evt_latency),
    .evt_resp_o        (evt_resp),
    .evt_beat_err_o    (evt_beat_err),
    .err_unknown_id_o  (err_unknown_id),
    .err_dup_issue_o   (err_dup_issue),
    .err_overflow_o    (err_overflow),
    .outstanding_cnt_o (outstanding_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the DUT timestamp (cycles since reset release) equals v.
  task automatic wait_ts(input logic [15:0] v);
    logic [15:0] c;
    c = 16'(cyc);
    while (c != v) begin
      step();
      c = 16'(cyc);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_id = 0; issue_addr = 0; issue_len = 0; issue_is_read = 0;
    b_valid = 0; b_ready = 0; b_id = 0; b_resp = 0;
    r_valid = 0; r_ready = 0; r_id = 0; r_resp = 0; r_last = 0;
  endtask

  task automatic do_issue(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic rd);
    issue_valid = 1; issue_id = id; issue_addr = addr; issue_len = len; issue_is_read = rd;
    step();
    issue_valid = 0;
  endtask

  task automatic do_b(input logic [3:0] id, input logic [1:0] resp);
    b_valid = 1; b_ready = 1; b_id = id; b_resp = resp;
    step();
    b_valid = 0; b_ready = 0;
  endtask

  task automatic do_r(input logic [3:0] id, input logic [1:0] resp, input logic last);
    r_valid = 1; r_ready = 1; r_id = id; r_resp = resp; r_last = last;
    step();
    r_valid = 0; r_ready = 0; r_last = 0;
  endtask

  initial begin
    logic [1:0] rresp [4];
    rresp[0] = 2'd0; rresp[1] = 2'd2; rresp[2] = 2'd0; rresp[3] = 2'd0;

    idle();
    evt_ready = 0;
    reset = 1;
    step();
    step();
    chk("rst_cnt",      outstanding_cnt, 0);
    chk("rst_evtv",     evt_valid, 0);
    chk("rst_dealloc",  dealloc_req, 0);
    chk("rst_ovf",      err_overflow, 0);
    chk("rst_unk",      err_unknown_id, 0);
    reset = 0;
    cyc = 0;

    // AW id=3 at ts=10, B OKAY at ts=25
    wait_ts(16'd10);
    do_issue(4'd3, 32'h1000, 8'd0, 1'b0);
    chk("t1_cnt_issue", outstanding_cnt, 1);
    wait_ts(16'd25);
    do_b(4'd3, 2'd0);
    chk("t1_evtv",  evt_valid, 1);
    chk("t1_id",    evt_id, 3);
    chk("t1_addr",  evt_addr, 32'h1000);
    chk("t1_lat",   evt_latency, 15);
    chk("t1_resp",  evt_resp, 0);
    chk("t1_dir",   evt_is_read, 0);
    chk("t1_cnt",   outstanding_cnt, 0);
    chk("t1_nodealloc_before_pop", dealloc_req, 0);
    evt_ready = 1;
    step();
    evt_ready = 0;
    chk("t1_dealloc",    dealloc_req, 1);
    chk("t1_dealloc_id", dealloc_id, 3);
    chk("t1_evtv_empty", evt_valid, 0);
    step();
    chk("t1_dealloc_end", dealloc_req, 0);

    // AR id=5 len=3, four beats with resp 0,2,0,0
    do_issue(4'd5, 32'h2000, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) do_r(4'd5, rresp[i], (i == 3));
    chk("t2_evtv",  evt_valid, 1);
    chk("t2_id",    evt_id, 5);
    chk("t2_resp",  evt_resp, 2);
    chk("t2_berr",  evt_beat_err, 0);
    chk("t2_dir",   evt_is_read, 1);
    chk("t2_lat",   evt_latency, 4);
    evt_ready = 1;
    step();
    evt_ready = 0;
    chk("t2_dealloc",    dealloc_req, 1);
    chk("t2_dealloc_id", dealloc_id, 5);
    step();
    chk("t2_single_dealloc", dealloc_req, 0);

    // AR id=7 len=3 ends after two beats
    do_issue(4'd7, 32'h3000, 8'd3, 1'b1);
    do_r(4'd7, 2'd0, 1'b0);
    do_r(4'd7, 2'd1, 1'b1);
    chk("t3_id",   evt_id, 7);
    chk("t3_berr", evt_beat_err, 1);
    chk("t3_resp", evt_resp, 1);
    evt_ready = 1;
    step();
    evt_ready = 0;
    chk("t3_dealloc_id", dealloc_id, 7);
    chk("t3_dealloc",    dealloc_req, 1);

    // B for id=9 that was never issued
    do_b(4'd9, 2'd0);
    chk("t3_unk",       err_unknown_id, 1);
    chk("t3_unk_evtv",  evt_valid, 0);
    step();
    chk("t3_unk_pulse", err_unknown_id, 0);
    chk("t3_unk_nodealloc", dealloc_req, 0);

    // Same-cycle B id=1 and R-last id=2
    do_issue(4'd1, 32'h0100, 8'd0, 1'b0);
    do_issue(4'd2, 32'h0200, 8'd0, 1'b1);
    chk("t4_cnt2", outstanding_cnt, 2);
    b_valid = 1; b_ready = 1; b_id = 4'd1; b_resp = 2'd3;
    r_valid = 1; r_ready = 1; r_id = 4'd2; r_resp = 2'd0; r_last = 1;
    step();
    idle();
    chk("t4_cnt0",   outstanding_cnt, 0);
    chk("t4_first",  evt_id, 1);
    chk("t4_bresp",  evt_resp, 3);
    evt_ready = 1;
    step();
    chk("t4_dealloc1",    dealloc_req, 1);
    chk("t4_dealloc1_id", dealloc_id, 1);
    chk("t4_second",      evt_id, 2);
    chk("t4_second_berr", evt_beat_err, 0);
    step();
    evt_ready = 0;
    chk("t4_dealloc2",    dealloc_req, 1);
    chk("t4_dealloc2_id", dealloc_id, 2);
    step();
    chk("t4_dealloc_end", dealloc_req, 0);
    chk("t4_no_ovf",      err_overflow, 0);

    // Five completions with evt_ready held low
    for (int i = 0; i < 5; i++) do_issue(4'(10 + i), 32'h4000 + 32'(i), 8'd0, 1'b0);
    chk("t5_cnt5", outstanding_cnt, 5);
    for (int i = 0; i < 5; i++) do_b(4'(10 + i), 2'd0);
    chk("t5_cnt0", outstanding_cnt, 0);
    chk("t5_ovf",  err_overflow, 1);
    evt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_evtv_%0d", i), evt_valid, 1);
      chk($sformatf("t5_id_%0d", i), evt_id, 10 + i);
      step();
      chk($sformatf("t5_dealloc_id_%0d", i), dealloc_id, 10 + i);
    end
    evt_ready = 0;
    chk("t5_only4", evt_valid, 0);
    chk("t5_ovf_sticky", err_overflow, 1);

    // Timestamp wrap: start 0xFFF0, end 0x0010
    wait_ts(16'hFFF0);
    do_issue(4'd4, 32'h5000, 8'd0, 1'b0);
    wait_ts(16'h0010);
    do_b(4'd4, 2'd0);
    chk("t6_id",  evt_id, 4);
    chk("t6_lat", evt_latency, 16'h0020);
    evt_ready = 1;
    step();
    evt_ready = 0;
    chk("t6_dealloc_id", dealloc_id, 4);

    // Duplicate issue, wrong direction, re-issue on completing ID
    do_issue(4'd6, 32'h6000, 8'd0, 1'b0);
    do_issue(4'd6, 32'h6100, 8'd0, 1'b0);
    chk("t7_dup",     err_dup_issue, 1);
    chk("t7_dup_cnt", outstanding_cnt, 1);
    step();
    chk("t7_dup_pulse", err_dup_issue, 0);
    issue_valid = 1; issue_id = 4'd6; issue_addr = 32'h6200; issue_len = 8'd0; issue_is_read = 1;
    b_valid = 1; b_ready = 1; b_id = 4'd6; b_resp = 2'd0;
    step();
    idle();
    chk("t7_swap_id",   evt_id, 6);
    chk("t7_swap_addr", evt_addr, 32'h6100);
    chk("t7_swap_dir",  evt_is_read, 0);
    chk("t7_swap_cnt",  outstanding_cnt, 1);
    chk("t7_swap_nodup", err_dup_issue, 0);
    evt_ready = 1;
    step();
    evt_ready = 0;
    do_b(4'd6, 2'd0);
    chk("t7_wrongdir",     err_unknown_id, 1);
    chk("t7_wrongdir_cnt", outstanding_cnt, 1);
    do_r(4'd6, 2'd2, 1'b1);
    chk("t7_rd_dir",  evt_is_read, 1);
    chk("t7_rd_addr", evt_addr, 32'h6200);
    chk("t7_rd_cnt",  outstanding_cnt, 0);
    evt_ready = 1;
    step();
    evt_ready = 0;

    // Reset with three outstanding and one queued record
    do_issue(4'd15, 32'h7000, 8'd0, 1'b0);
    do_b(4'd15, 2'd0);
    do_issue(4'd6,  32'h7100, 8'd0, 1'b0);
    do_issue(4'd8,  32'h7200, 8'd0, 1'b0);
    do_issue(4'd11, 32'h7300, 8'd0, 1'b0);
    chk("t8_cnt3", outstanding_cnt, 3);
    chk("t8_evtv", evt_valid, 1);
    reset = 1;
    #1;
    chk("t8_rst_cnt",  outstanding_cnt, 0);
    chk("t8_rst_evtv", evt_valid, 0);
    chk("t8_rst_ovf",  err_overflow, 0);
    evt_ready = 1;
    step();
    chk("t8_rst_nodealloc", dealloc_req, 0);
    step();
    reset = 0;
    cyc = 0;
    step();
    chk("t8_post_nodealloc", dealloc_req, 0);
    do_b(4'd6, 2'd0);
    chk("t8_unk", err_unknown_id, 1);
    chk("t8_unk_evtv", evt_valid, 0);
    step();
    chk("t8_unk_nodealloc", dealloc_req, 0);
    chk("t8_cnt_end", outstanding_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
